// File: rtl/present_enc_sched.sv
// Round-robin scheduler that time-shares one PRESENT-80 core between two requesters.
// It counts the core's rounds and captures the ciphertext in the single cycle it is valid.
module present_enc_sched #(
    parameter int CORE_CYCLES = 31,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_pt,
    input  logic [79:0] req0_key,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_pt,
    input  logic [79:0] req1_key,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_ct,
    output logic        rsp_id,
    output logic        core_load,
    output logic [63:0] core_idat,
    output logic [79:0] core_key,
    input  logic [63:0] core_odat,
    output logic        busy
);

    // Handshakes: a transfer happens on the rising edge where valid && ready.
    // Requesters may drop valid before acceptance. rsp_ct/rsp_id hold while
    // rsp_valid && !rsp_ready.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             rr_ptr;
    logic             id_reg;
    logic             grant_vld;
    logic             grant_id;

    // A grant needs a free capture slot, so a pending response stalls all new jobs.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (!rst && state == IDLE && !rsp_valid) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = rr_ptr;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    always_comb begin
        core_load  = grant_vld;
        req0_ready = grant_vld && !grant_id;
        req1_ready = grant_vld && grant_id;
        core_idat  = '0;
        core_key   = '0;
        if (grant_vld) begin
            core_idat = grant_id ? req1_pt : req0_pt;
            core_key  = grant_id ? req1_key : req0_key;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = RUN;
            RUN:     if (cnt == CNT_LAST) state_nxt = CAP;
            CAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= 1'b0;
            id_reg    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_ct    <= '0;
            rsp_id    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        id_reg <= grant_id;
                        rr_ptr <= ~grant_id;
                        cnt    <= '0;
                    end
                end
                RUN: cnt <= cnt + 1'b1;
                // core_odat holds the ciphertext only in this cycle; the slot is known free
                CAP: begin
                    rsp_ct    <= core_odat;
                    rsp_id    <= id_reg;
                    rsp_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_present_enc_sched.sv
// Bench for present_enc_sched: behavioural PRESENT-80 core, scheduler reference model,
// directed known-answer tests and randomized traffic.
module tb_present_enc_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_pt = '0, req1_pt = '0;
    logic [79:0] req0_key = '0, req1_key = '0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [63:0] rsp_ct;
    logic        rsp_id;
    logic        core_load;
    logic [63:0] core_idat;
    logic [79:0] core_key;
    logic [63:0] core_odat;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [63:0] ONES64 = {64{1'b1}};
    localparam logic [79:0] ONES80 = {80{1'b1}};

    present_enc_sched dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pt(req0_pt), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pt(req1_pt), .req1_key(req1_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ct(rsp_ct), .rsp_id(rsp_id),
        .core_load(core_load), .core_idat(core_idat), .core_key(core_key), .core_odat(core_odat),
        .busy(busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- PRESENT-80 reference ----------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC; 4'h1: sbox = 4'h5; 4'h2: sbox = 4'h6; 4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9; 4'h5: sbox = 4'h0; 4'h6: sbox = 4'hA; 4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3; 4'h9: sbox = 4'hE; 4'hA: sbox = 4'hF; 4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4; 4'hD: sbox = 4'h7; 4'hE: sbox = 4'h1; default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] present80(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s;
        logic [63:0] t;
        logic [79:0] k;
        int p;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int i = 0; i < 16; i++) t[4*i +: 4] = sbox(s[4*i +: 4]);
            for (int i = 0; i < 64; i++) begin
                p = (i == 63) ? 63 : (i * 16) % 63;
                s[p] = t[i];
            end
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    // Core model: result appears after 31 non-load edges, garbage at every other time.
    logic [63:0] core_ct  = '0;
    logic [63:0] core_junk = '0;
    int          core_cnt = 63;
    always @(posedge clk) begin
        if (core_load) begin
            core_ct  <= present80(core_idat, core_key);
            core_cnt <= 0;
        end else if (core_cnt != 63) begin
            core_cnt <= core_cnt + 1;
        end
        core_junk <= {$urandom, $urandom};
    end
    assign core_odat = (core_cnt == 31) ? core_ct : core_junk;

    // ---------------- scoreboard / reference model ----------------
    logic [64:0] exp_q[$];
    int cyc = 0;
    int load_cyc = 0;
    bit inflight = 1'b0;
    bit m_rsp = 1'b0;
    bit m_rr = 1'b0;

    always @(negedge clk) begin
        bit free;
        bit exp_g;
        bit eid;
        cyc++;
        if (rst) begin
            check("rst_load", core_load, 0);
            check("rst_ready", {req1_ready, req0_ready}, 0);
            check("rst_idat", core_idat, 0);
            check("rst_key", core_key, 0);
            inflight = 1'b0;
            m_rsp    = 1'b0;
            m_rr     = 1'b0;
            exp_q.delete();
        end else begin
            if (inflight && cyc == load_cyc + 33) begin
                inflight = 1'b0;
                m_rsp    = 1'b1;
                check("rsp_arrive", rsp_valid, 1);
                check("rsp_arrive_ct", rsp_ct, exp_q[0][63:0]);
                check("rsp_arrive_id", rsp_id, exp_q[0][64]);
            end else begin
                check("rsp_valid", rsp_valid, m_rsp);
            end
            check("busy", busy, inflight);
            free  = !inflight && !m_rsp;
            exp_g = free && (req0_valid || req1_valid);
            check("grant", req0_ready | req1_ready, exp_g);
            check("core_load", core_load, exp_g);
            if (exp_g) begin
                eid = (req0_valid && req1_valid) ? m_rr : req1_valid;
                check("grant_id", {req1_ready, req0_ready}, eid ? 2'b10 : 2'b01);
                check("load_idat", core_idat, eid ? req1_pt : req0_pt);
                check("load_key", core_key, eid ? req1_key : req0_key);
                exp_q.push_back({eid, present80(eid ? req1_pt : req0_pt, eid ? req1_key : req0_key)});
                m_rr     = ~eid;
                inflight = 1'b1;
                load_cyc = cyc;
            end else if (inflight) begin
                check("run_idat", core_idat, 0);
                check("run_key", core_key, 0);
            end
            if (m_rsp && rsp_ready) begin
                check("rsp_take_ct", rsp_ct, exp_q[0][63:0]);
                check("rsp_take_id", rsp_id, exp_q[0][64]);
                void'(exp_q.pop_front());
                m_rsp = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic send(input bit id, input logic [63:0] pt, input logic [79:0] key);
        int n;
        n = 0;
        if (id) begin
            req1_valid = 1'b1; req1_pt = pt; req1_key = key;
        end else begin
            req0_valid = 1'b1; req0_pt = pt; req0_key = key;
        end
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 300) begin
            step();
            #1;
            n++;
        end
        check("send_wait", n < 300, 1);
        check("send_load", core_load, 1);
        step();
        if (id) req1_valid = 1'b0;
        else req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [63:0] ect, input bit eid,
                            output int lat, output int nbusy);
        lat = 0;
        nbusy = 0;
        while (!rsp_valid && lat < 200) begin
            if (busy) nbusy++;
            step();
            lat++;
        end
        check({tag, "_seen"}, rsp_valid, 1);
        check({tag, "_ct"}, rsp_ct, ect);
        check({tag, "_id"}, rsp_id, eid);
        rsp_ready = 1'b1;
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, nbusy, n, bad_hold, bad_grant;
        bit g[$];
        logic [64:0] got[$];
        logic [63:0] hold_ct;
        logic hold_id;
        bit hs0, hs1;

        do_reset();
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_rsp_ct", rsp_ct, 0);
        check("reset_rsp_id", rsp_id, 0);

        // single requester known answers
        send(0, 64'h0, 80'h0);
        wait_rsp("kat0", 64'h5579c1387b228445, 0, lat, nbusy);
        check("kat0_latency", lat, 32);
        send(1, 64'h0, ONES80);
        wait_rsp("kat1", 64'he72c46c0f5945049, 1, lat, nbusy);
        check("kat1_busy_cycles", nbusy, 32);

        // both valid continuously: alternation from requester 0 after reset
        do_reset();
        rsp_ready = 1'b1;
        req0_pt = ONES64; req0_key = 80'h0;
        req1_pt = ONES64; req1_key = ONES80;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n = 0;
        while (got.size() < 3 && n < 400) begin
            if (req0_ready) g.push_back(1'b0);
            if (req1_ready) g.push_back(1'b1);
            if (rsp_valid && rsp_ready) got.push_back({rsp_id, rsp_ct});
            step();
            n++;
        end
        check("alt_rsp_count", got.size(), 3);
        check("alt_grant_count", g.size(), 3);
        if (g.size() >= 3) check("alt_grants", {g[0], g[1], g[2]}, 3'b010);
        if (got.size() >= 3) begin
            check("alt_rsp0", got[0], {1'b0, 64'ha112ffc72f68417b});
            check("alt_rsp1", got[1], {1'b1, 64'h3333dcd3213210d2});
            check("alt_rsp2", got[2], {1'b0, 64'ha112ffc72f68417b});
        end

        // backpressure on the next response (requester 1's job)
        n = 0;
        while (!rsp_valid && n < 100) begin
            step();
            n++;
        end
        rsp_ready = 1'b0;
        check("bp_seen", rsp_valid, 1);
        check("bp_ct", rsp_ct, 64'h3333dcd3213210d2);
        hold_ct = rsp_ct;
        hold_id = rsp_id;
        bad_hold = 0;
        bad_grant = 0;
        repeat (50) begin
            step();
            if (!rsp_valid || rsp_ct !== hold_ct || rsp_id !== hold_id) bad_hold++;
            if (req0_ready || req1_ready || core_load) bad_grant++;
        end
        check("bp_hold", bad_hold, 0);
        check("bp_no_grant", bad_grant, 0);
        rsp_ready = 1'b1;
        step();
        check("bp_drained", rsp_valid, 0);
        check("bp_resume_grant", {req1_ready, req0_ready}, 2'b01);
        check("bp_resume_load", core_load, 1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (40) step();

        // reset mid-job: no response, next job still correct
        do_reset();
        send(0, {$urandom, $urandom}, {$urandom, $urandom, 16'($urandom)});
        repeat (10) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        n = 0;
        repeat (45) begin
            if (rsp_valid) n++;
            step();
        end
        check("midrst_no_rsp", n, 0);
        send(0, 64'h0, 80'h0);
        wait_rsp("midrst_kat", 64'h5579c1387b228445, 0, lat, nbusy);

        // randomized traffic, checked by the scoreboard
        hs0 = 1'b0;
        hs1 = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!req0_valid || hs0) begin
                req0_valid = ($urandom_range(0, 2) == 0);
                req0_pt    = {$urandom, $urandom};
                req0_key   = {$urandom, $urandom, 16'($urandom)};
            end else if ($urandom_range(0, 49) == 0) begin
                req0_valid = 1'b0;
            end
            if (!req1_valid || hs1) begin
                req1_valid = ($urandom_range(0, 2) == 0);
                req1_pt    = {$urandom, $urandom};
                req1_key   = {$urandom, $urandom, 16'($urandom)};
            end else if ($urandom_range(0, 49) == 0) begin
                req1_valid = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 1) == 1);
            #1;
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (80) step();
        check("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
